// File: rtl/nes_pkg.sv
// Shared NES controller definitions: button bit positions used across the design,
// plus the pad reader's state encoding and phase-counter type.
package nes_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int PHASE_W = 10;
  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CLK_LOW,
    ST_CLK_HIGH,
    ST_DONE
  } reader_state_t;

  // A phase of N cycles is timed by loading N-1 and running down to zero.
  function automatic phase_t phase_reload(input int unsigned cycles);
    return phase_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/nes_pad_reader_if.sv
// Pad connector pins plus the game-side frame strobe and button results.
interface nes_pad_reader_if;

  logic       vSyncStart;
  logic       padData;
  logic       padLatch;
  logic       padClock;
  logic [7:0] buttons;
  logic [7:0] pressed;
  logic       buttonsValid;
  logic       busy;

  // The reader drives the pad strobes and publishes the results.
  modport master (
    input  vSyncStart, padData,
    output padLatch, padClock, buttons, pressed, buttonsValid, busy
  );

  modport slave (
    output vSyncStart, padData,
    input  padLatch, padClock, buttons, pressed, buttonsValid, busy
  );

endinterface

// File: rtl/nes_pad_phase_timer.sv
// Loadable 10-bit down-counter; tc is high once the loaded phase has run out.
module nes_pad_phase_timer
  import nes_pkg::*;
(
  input  logic   pixelClock,
  input  logic   reset,
  input  logic   load,
  input  phase_t load_value,
  output logic   tc
);

  phase_t count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation order between processes cannot matter.
  always_ff @(posedge pixelClock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/nes_pad_reader.sv
// Once-per-frame CD4021 pad reader: latch, eight clocked samples, then publish
// active-high buttons and newly-pressed flags with a one-cycle valid pulse.
module nes_pad_reader
  import nes_pkg::*;
#(
  parameter int LATCH_CYCLES       = 300,
  parameter int HALF_PERIOD_CYCLES = 150
) (
  input  logic             pixelClock,
  input  logic             reset,
  nes_pad_reader_if.master pad
);

  localparam phase_t   LATCH_RELOAD = phase_reload(LATCH_CYCLES);
  localparam phase_t   HALF_RELOAD  = phase_reload(HALF_PERIOD_CYCLES);
  // The pad shifts out A first and Right last.
  localparam logic [2:0] FIRST_BIT  = 3'(BTN_A);
  localparam logic [2:0] LAST_BIT   = 3'(BTN_RIGHT);

  reader_state_t state;
  reader_state_t state_next;

  logic       timer_load;
  phase_t     timer_value;
  logic       phase_end;
  logic       sample_bit;
  logic       bit_clear;
  logic       bit_advance;
  logic [2:0] bit_idx;
  logic [7:0] shift;

  nes_pad_phase_timer u_phase_timer (
    .pixelClock (pixelClock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .tc         (phase_end)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    timer_load  = 1'b0;
    timer_value = '0;
    sample_bit  = 1'b0;
    bit_clear   = 1'b0;
    bit_advance = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pad.vSyncStart) begin
          state_next  = ST_LATCH;
          timer_load  = 1'b1;
          timer_value = LATCH_RELOAD;
          bit_clear   = 1'b1;
        end
      end
      ST_LATCH: begin
        if (phase_end) begin
          state_next  = ST_CLK_LOW;
          timer_load  = 1'b1;
          timer_value = HALF_RELOAD;
          bit_clear   = 1'b1;
        end
      end
      ST_CLK_LOW: begin
        if (phase_end) begin
          sample_bit  = 1'b1;
          state_next  = ST_CLK_HIGH;
          timer_load  = 1'b1;
          timer_value = HALF_RELOAD;
        end
      end
      ST_CLK_HIGH: begin
        if (phase_end) begin
          if (bit_idx == LAST_BIT) begin
            state_next = ST_DONE;
          end else begin
            bit_advance = 1'b1;
            state_next  = ST_CLK_LOW;
            timer_load  = 1'b1;
            timer_value = HALF_RELOAD;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so the pad pins never glitch.
  always_ff @(posedge pixelClock) begin
    if (reset) begin
      state            <= ST_IDLE;
      bit_idx          <= FIRST_BIT;
      shift            <= '0;
      pad.padLatch     <= 1'b0;
      pad.padClock     <= 1'b0;
      pad.busy         <= 1'b0;
      pad.buttonsValid <= 1'b0;
      pad.buttons      <= '0;
      pad.pressed      <= '0;
    end else begin
      state <= state_next;

      if (bit_clear) begin
        bit_idx <= FIRST_BIT;
      end else if (bit_advance) begin
        bit_idx <= bit_idx + 1'b1;
      end

      // Pad data is active-low; store it as active-high.
      if (sample_bit) begin
        shift[bit_idx] <= ~pad.padData;
      end

      pad.padLatch     <= (state_next == ST_LATCH);
      pad.padClock     <= (state_next == ST_CLK_HIGH);
      pad.busy         <= (state_next != ST_IDLE);
      pad.buttonsValid <= (state_next == ST_DONE);

      if (state_next == ST_DONE) begin
        pad.buttons <= shift;
        pad.pressed <= shift & ~pad.buttons;
      end
    end
  end

endmodule
